// File: rtl/hazard_ctrl_if.sv
// ----------------------------------------------------------------------------
// hazard_ctrl_if
// Groups the hazard-detection inputs and the pipeline-control outputs of
// hazard_ctrl. The pipeline side uses the master modport, and hazard_ctrl
// uses the slave modport.
//   id_rs_i / id_rt_i / id_uses_rt_i : source fields of the instruction in ID
//   ex_memread_i / ex_rt_i           : load in EX and its destination
//   branch_taken_i / jump_i          : control-flow redirect resolved in ID
//   dmem_busy_i                      : data memory still busy this cycle
//   pc_write_o .. exmem_hold_o       : pipeline register controls
//   state_o                          : 0=RUN, 1=FLUSH, 2=DMEM_WAIT
//   stall_cnt_o / flush_cnt_o        : saturating performance counters
// ----------------------------------------------------------------------------
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs_i;
    logic [4:0]       id_rt_i;
    logic             id_uses_rt_i;
    logic             ex_memread_i;
    logic [4:0]       ex_rt_i;
    logic             branch_taken_i;
    logic             jump_i;
    logic             dmem_busy_i;
    logic             pc_write_o;
    logic             ifid_hold_o;
    logic             ifid_flush_o;
    logic             idex_bubble_o;
    logic             exmem_hold_o;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;

    modport master (
        output id_rs_i, id_rt_i, id_uses_rt_i, ex_memread_i, ex_rt_i,
               branch_taken_i, jump_i, dmem_busy_i,
        input  pc_write_o, ifid_hold_o, ifid_flush_o, idex_bubble_o,
               exmem_hold_o, state_o, stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  id_rs_i, id_rt_i, id_uses_rt_i, ex_memread_i, ex_rt_i,
               branch_taken_i, jump_i, dmem_busy_i,
        output pc_write_o, ifid_hold_o, ifid_flush_o, idex_bubble_o,
               exmem_hold_o, state_o, stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/hazard_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline control unit for the 5-stage core. It handles load-use stalls,
// data-memory wait freezes and branch/jump flushes with the fixed priority
// dmem_busy > load-use > branch/jump. It also keeps saturating counts of
// stall cycles and flush cycles.
// Ports:
//   clk_i  : clock; all state updates on the rising edge
//   rst_i  : asynchronous active-low reset; control outputs are forced while low
//   bus    : hazard_ctrl_if.slave (hazard inputs, control outputs, counters)
// Parameters:
//   BRANCH_PENALTY : IF/ID flush cycles per taken branch/jump (1..4)
//   CNT_W          : width of the performance counters
// ----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int BRANCH_PENALTY = 1,
    parameter int CNT_W          = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    hazard_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        RUN       = 2'd0,
        FLUSH     = 2'd1,
        DMEM_WAIT = 2'd2
    } state_t;

    localparam logic [2:0] PEN_M1 = 3'(BRANCH_PENALTY - 1);

    state_t           r_state, w_next_state;
    logic [2:0]       r_rem, w_next_rem;
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
    logic             w_lu;
    logic             w_pc_write, w_ifid_hold, w_ifid_flush;
    logic             w_idex_bubble, w_exmem_hold;

    // $zero is never a real dependency; rt counts only when the ID op reads it.
    assign w_lu = bus.ex_memread_i && (bus.ex_rt_i != 5'd0) &&
                  ((bus.ex_rt_i == bus.id_rs_i) ||
                   (bus.id_uses_rt_i && (bus.ex_rt_i == bus.id_rt_i)));

    always_comb begin
        w_next_state  = r_state;
        w_next_rem    = r_rem;
        w_pc_write    = 1'b1;
        w_ifid_hold   = 1'b0;
        w_ifid_flush  = 1'b0;
        w_idex_bubble = 1'b0;
        w_exmem_hold  = 1'b0;
        if (!rst_i) begin
            w_pc_write    = 1'b0;
            w_ifid_flush  = 1'b1;
            w_idex_bubble = 1'b1;
            w_next_state  = RUN;
            w_next_rem    = '0;
        end else if (bus.dmem_busy_i) begin
            // The freeze pattern applies in every state. A flush sequence
            // in progress is paused rather than abandoned.
            w_pc_write   = 1'b0;
            w_ifid_hold  = 1'b1;
            w_exmem_hold = 1'b1;
            w_next_state = (r_state == FLUSH) ? FLUSH : DMEM_WAIT;
        end else if (r_state == FLUSH) begin
            // Wrong-path cycles: hazards and redirects seen here are ignored.
            w_ifid_flush = 1'b1;
            w_next_rem   = r_rem - 3'd1;
            if (r_rem == 3'd1)
                w_next_state = RUN;
        end else begin
            // RUN, or DMEM_WAIT with the wait just finished (no dead cycle).
            w_next_state = RUN;
            if (w_lu) begin
                w_pc_write    = 1'b0;
                w_ifid_hold   = 1'b1;
                w_idex_bubble = 1'b1;
            end else if (bus.branch_taken_i || bus.jump_i) begin
                w_ifid_flush = 1'b1;
                if (PEN_M1 != '0) begin
                    w_next_state = FLUSH;
                    w_next_rem   = PEN_M1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state     <= RUN;
            r_rem       <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            r_rem   <= w_next_rem;
            if (!w_pc_write && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (w_ifid_flush && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign bus.pc_write_o    = w_pc_write;
    assign bus.ifid_hold_o   = w_ifid_hold;
    assign bus.ifid_flush_o  = w_ifid_flush;
    assign bus.idex_bubble_o = w_idex_bubble;
    assign bus.exmem_hold_o  = w_exmem_hold;
    assign bus.state_o       = r_state;
    assign bus.stall_cnt_o   = r_stall_cnt;
    assign bus.flush_cnt_o   = r_flush_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_hazard_ctrl
// Three hazard_ctrl instances share one stimulus stream:
//   dut_a : BRANCH_PENALTY=3, CNT_W=16
//   dut_b : BRANCH_PENALTY=2, CNT_W=4
//   dut_c : BRANCH_PENALTY=1, CNT_W=16
// A model tracks the number of flush cycles still owed and the counters. On
// every falling edge it is compared with all three instances. Directed
// scenarios also check hand-computed literal values.
// Control vectors are packed as {pc_write, ifid_hold, ifid_flush, idex_bubble, exmem_hold}.
// ----------------------------------------------------------------------------
module tb_hazard_ctrl;
    localparam logic [4:0] C_NORM  = 5'b10000;
    localparam logic [4:0] C_STALL = 5'b01010;
    localparam logic [4:0] C_FRZ   = 5'b01001;
    localparam logic [4:0] C_FLUSH = 5'b10100;
    localparam logic [4:0] C_RST   = 5'b00110;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       uses_rt, memrd, br, jmp, busy;

    int unsigned tests = 0;
    int unsigned fails = 0;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(16)) if_a ();
    hazard_ctrl_if #(.CNT_W(4))  if_b ();
    hazard_ctrl_if #(.CNT_W(16)) if_c ();

    assign if_a.id_rs_i = id_rs;  assign if_b.id_rs_i = id_rs;  assign if_c.id_rs_i = id_rs;
    assign if_a.id_rt_i = id_rt;  assign if_b.id_rt_i = id_rt;  assign if_c.id_rt_i = id_rt;
    assign if_a.ex_rt_i = ex_rt;  assign if_b.ex_rt_i = ex_rt;  assign if_c.ex_rt_i = ex_rt;
    assign if_a.id_uses_rt_i = uses_rt; assign if_b.id_uses_rt_i = uses_rt; assign if_c.id_uses_rt_i = uses_rt;
    assign if_a.ex_memread_i = memrd;   assign if_b.ex_memread_i = memrd;   assign if_c.ex_memread_i = memrd;
    assign if_a.branch_taken_i = br;    assign if_b.branch_taken_i = br;    assign if_c.branch_taken_i = br;
    assign if_a.jump_i = jmp;           assign if_b.jump_i = jmp;           assign if_c.jump_i = jmp;
    assign if_a.dmem_busy_i = busy;     assign if_b.dmem_busy_i = busy;     assign if_c.dmem_busy_i = busy;

    hazard_ctrl #(.BRANCH_PENALTY(3), .CNT_W(16)) dut_a (.clk_i(clk), .rst_i(rst_n), .bus(if_a));
    hazard_ctrl #(.BRANCH_PENALTY(2), .CNT_W(4))  dut_b (.clk_i(clk), .rst_i(rst_n), .bus(if_b));
    hazard_ctrl #(.BRANCH_PENALTY(1), .CNT_W(16)) dut_c (.clk_i(clk), .rst_i(rst_n), .bus(if_c));

    logic [4:0]  act_ctrl [3];
    logic [1:0]  act_st   [3];
    logic [15:0] act_sc   [3];
    logic [15:0] act_fc   [3];

    assign act_ctrl[0] = {if_a.pc_write_o, if_a.ifid_hold_o, if_a.ifid_flush_o, if_a.idex_bubble_o, if_a.exmem_hold_o};
    assign act_ctrl[1] = {if_b.pc_write_o, if_b.ifid_hold_o, if_b.ifid_flush_o, if_b.idex_bubble_o, if_b.exmem_hold_o};
    assign act_ctrl[2] = {if_c.pc_write_o, if_c.ifid_hold_o, if_c.ifid_flush_o, if_c.idex_bubble_o, if_c.exmem_hold_o};
    assign act_st[0] = if_a.state_o;  assign act_st[1] = if_b.state_o;  assign act_st[2] = if_c.state_o;
    assign act_sc[0] = if_a.stall_cnt_o; assign act_sc[1] = 16'(if_b.stall_cnt_o); assign act_sc[2] = if_c.stall_cnt_o;
    assign act_fc[0] = if_a.flush_cnt_o; assign act_fc[1] = 16'(if_b.flush_cnt_o); assign act_fc[2] = if_c.flush_cnt_o;

    // ---------------- model ----------------
    localparam int unsigned PEN  [3] = '{3, 2, 1};
    localparam int unsigned CMAX [3] = '{65535, 15, 65535};

    int unsigned pend  [3] = '{0, 0, 0};   // flush cycles still owed after the first
    bit          waitf [3] = '{0, 0, 0};   // last edge froze outside a flush sequence
    int unsigned scnt  [3] = '{0, 0, 0};
    int unsigned fcnt  [3] = '{0, 0, 0};

    function automatic bit lu_now();
        return memrd && (ex_rt != 5'd0) &&
               ((ex_rt == id_rs) || (uses_rt && (ex_rt == id_rt)));
    endfunction

    function automatic logic [4:0] model_ctrl(int unsigned p);
        if (!rst_n)      return C_RST;
        if (busy)        return C_FRZ;
        if (p > 0)       return C_FLUSH;
        if (lu_now())    return C_STALL;
        if (br || jmp)   return C_FLUSH;
        return C_NORM;
    endfunction

    function automatic bit m_stall(int unsigned p);
        logic [4:0] c;
        c = model_ctrl(p);
        return !c[4];
    endfunction

    function automatic bit m_flush(int unsigned p);
        logic [4:0] c;
        c = model_ctrl(p);
        return c[2];
    endfunction

    function automatic int unsigned sat_inc(int unsigned v, int unsigned mx, bit en);
        return (en && v < mx) ? v + 1 : v;
    endfunction

    function automatic int unsigned next_pend(int unsigned p, int unsigned pen);
        if (busy)                        return p;
        if (p > 0)                       return p - 1;
        if (!lu_now() && (br || jmp))    return pen - 1;
        return 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                pend[k]  <= 0;
                waitf[k] <= 1'b0;
                scnt[k]  <= 0;
                fcnt[k]  <= 0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                scnt[k]  <= sat_inc(scnt[k], CMAX[k], m_stall(pend[k]));
                fcnt[k]  <= sat_inc(fcnt[k], CMAX[k], m_flush(pend[k]));
                waitf[k] <= busy && (pend[k] == 0);
                pend[k]  <= next_pend(pend[k], PEN[k]);
            end
        end
    end

    task automatic chk(string name, int unsigned act, int unsigned exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("ctrl[%0d]", k), 32'(act_ctrl[k]), 32'(model_ctrl(pend[k])));
            chk($sformatf("state[%0d]", k), 32'(act_st[k]),
                (pend[k] > 0) ? 1 : (waitf[k] ? 2 : 0));
            chk($sformatf("stall_cnt[%0d]", k), 32'(act_sc[k]), scnt[k]);
            chk($sformatf("flush_cnt[%0d]", k), 32'(act_fc[k]), fcnt[k]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        id_rs = '0; id_rt = '0; ex_rt = '0;
        uses_rt = 1'b0; memrd = 1'b0; br = 1'b0; jmp = 1'b0; busy = 1'b0;
    endtask

    task automatic do_reset();
        clear_in();
        rst_n = 1'b0;
        #1;
        chk("rst_ctrl_a", 32'(act_ctrl[0]), 32'(C_RST));
        tick();
        rst_n = 1'b1;
        #1;
        chk("rst_state_a", 32'(act_st[0]), 0);
        chk("rst_stall_a", 32'(act_sc[0]), 0);
        chk("rst_flush_a", 32'(act_fc[0]), 0);
    endtask

    initial begin
        clear_in();
        #1;
        do_reset();

        // Load-use on rs for one cycle
        memrd = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
        #1 chk("lu_ctrl", 32'(act_ctrl[0]), 32'(C_STALL));
        tick();
        memrd = 1'b0;
        #1 chk("lu_after", 32'(act_ctrl[0]), 32'(C_NORM));
        tick();
        chk("lu_stall_cnt", 32'(act_sc[0]), 1);

        // $zero and unused-rt exclusions
        memrd = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
        #1 chk("zero_excl", 32'(act_ctrl[0]), 32'(C_NORM));
        ex_rt = 5'd7; id_rt = 5'd7; id_rs = 5'd3; uses_rt = 1'b0;
        #1 chk("rt_unused", 32'(act_ctrl[0]), 32'(C_NORM));
        uses_rt = 1'b1;
        #1 chk("rt_used", 32'(act_ctrl[0]), 32'(C_STALL));
        clear_in();
        tick();

        // Branch: penalty 3 on dut_a, repeated branch in cycle 2 ignored
        do_reset();
        br = 1'b1;
        #1 chk("br_c1", 32'(act_ctrl[0]), 32'(C_FLUSH));
        tick();
        chk("br_state", 32'(act_st[0]), 1);
        #1 chk("br_c2", 32'(act_ctrl[0]), 32'(C_FLUSH));
        tick();
        br = 1'b0;
        #1 chk("br_c3", 32'(act_ctrl[0]), 32'(C_FLUSH));
        tick();
        chk("br_c4", 32'(act_ctrl[0]), 32'(C_NORM));
        chk("br_state_end", 32'(act_st[0]), 0);
        chk("br_flush_a", 32'(act_fc[0]), 3);
        chk("br_flush_c", 32'(act_fc[2]), 2);

        // dmem_busy for 4 cycles with a load-use and a branch pending
        do_reset();
        busy = 1'b1; memrd = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; br = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 chk("busy_frz", 32'(act_ctrl[0]), 32'(C_FRZ));
            tick();
        end
        chk("busy_state", 32'(act_st[0]), 2);
        busy = 1'b0;
        #1 chk("busy_lu", 32'(act_ctrl[0]), 32'(C_STALL));
        tick();
        clear_in();
        #1 chk("busy_done", 32'(act_ctrl[0]), 32'(C_NORM));
        chk("busy_stall_cnt", 32'(act_sc[0]), 5);
        chk("busy_flush_cnt", 32'(act_fc[0]), 0);

        // dmem_busy in the middle of a penalty-2 flush (dut_b)
        do_reset();
        br = 1'b1;
        tick();
        br = 1'b0; busy = 1'b1;
        #1 chk("fb_frz", 32'(act_ctrl[1]), 32'(C_FRZ));
        tick();
        tick();
        busy = 1'b0;
        #1 chk("fb_resume", 32'(act_ctrl[1]), 32'(C_FLUSH));
        tick();
        #1 chk("fb_done", 32'(act_ctrl[1]), 32'(C_NORM));
        chk("fb_flush_b", 32'(act_fc[1]), 2);
        chk("fb_state_b", 32'(act_st[1]), 0);
        tick();
        tick();

        // Asynchronous reset in the middle of a flush
        do_reset();
        br = 1'b1;
        tick();
        br = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("ar_ctrl", 32'(act_ctrl[0]), 32'(C_RST));
        chk("ar_state", 32'(act_st[0]), 0);
        chk("ar_flush", 32'(act_fc[0]), 0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("ar_rel_ctrl", 32'(act_ctrl[0]), 32'(C_NORM));
        chk("ar_rel_state", 32'(act_st[0]), 0);

        // Saturation of the 4-bit stall counter
        do_reset();
        busy = 1'b1;
        repeat (20) tick();
        chk("sat_stall_b", 32'(act_sc[1]), 15);
        chk("sat_stall_a", 32'(act_sc[0]), 20);
        busy = 1'b0;
        tick();

        // Mixed pseudo-random traffic, checked by the model
        for (int i = 0; i < 80; i++) begin
            memrd   = ($urandom_range(0, 1) == 1);
            ex_rt   = 5'($urandom_range(0, 3));
            id_rs   = 5'($urandom_range(0, 3));
            id_rt   = 5'($urandom_range(0, 3));
            uses_rt = ($urandom_range(0, 1) == 1);
            br      = ($urandom_range(0, 4) == 0);
            jmp     = ($urandom_range(0, 6) == 0);
            busy    = ($urandom_range(0, 3) == 0);
            tick();
        end
        clear_in();
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
